// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU and load writebacks,
// registered write strobe, and a per-register busy scoreboard for decode hazards.
module regfile_wb_arbiter #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_rd,
    output logic              rsv_ready,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    output logic              stall,
    output logic [NREGS-1:0]  busy,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] WriteD,
    output logic              wb_err
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // ready is combinational, never high without its valid, and at most one
    // source is ready per cycle; a source holds rd/data while valid && !ready.
    logic              r_prio_mem;
    logic              r_regwrite;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic [NREGS-1:0]  r_busy;
    logic              r_err;

    logic              w_alu_grant;
    logic              w_mem_grant;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_data;
    logic              w_rsv_ready;
    logic              w_rsv_fire;
    logic [NREGS-1:0]  w_busy_next;

    always_comb begin
        w_alu_grant = alu_valid && (!mem_valid || !r_prio_mem);
        w_mem_grant = mem_valid && (!alu_valid || r_prio_mem);
        w_xfer      = w_alu_grant || w_mem_grant;
        w_rd        = w_alu_grant ? alu_rd   : mem_rd;
        w_data      = w_alu_grant ? alu_data : mem_data;
    end

    // A register being committed this cycle may be re-reserved immediately.
    always_comb begin
        w_rsv_ready = !r_busy[rsv_rd] || (r_regwrite && (r_rd == rsv_rd));
        w_rsv_fire  = rsv_valid && w_rsv_ready;
        w_busy_next = r_busy;
        if (r_regwrite) begin
            w_busy_next[r_rd] = 1'b0;
        end
        if (w_rsv_fire) begin
            w_busy_next[rsv_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prio_mem <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_data     <= '0;
            r_busy     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_regwrite <= w_xfer;
            r_busy     <= w_busy_next;
            if (w_xfer) begin
                r_rd       <= w_rd;
                r_data     <= w_data;
                r_prio_mem <= w_alu_grant;
                if (!r_busy[w_rd]) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign alu_ready = w_alu_grant;
    assign mem_ready = w_mem_grant;
    assign rsv_ready = w_rsv_ready;
    assign stall     = r_busy[Rs] || r_busy[Rt];
    assign busy      = r_busy;
    assign RegWrite  = r_regwrite;
    assign Rd        = r_rd;
    assign WriteD    = r_data;
    assign wb_err    = r_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: driver pushes expected commits into a
// queue, a negedge monitor pops and compares every RegWrite strobe.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;
    localparam int EW     = ADDR_W + DATA_W;

    logic              clock;
    logic              reset;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_rd;
    logic              rsv_ready;
    logic [ADDR_W-1:0] Rs;
    logic [ADDR_W-1:0] Rt;
    logic              stall;
    logic [NREGS-1:0]  busy;
    logic              RegWrite;
    logic [ADDR_W-1:0] Rd;
    logic [DATA_W-1:0] WriteD;
    logic              wb_err;

    logic [EW-1:0] exp_q[$];
    int checks;
    int errors;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
        .Rs(Rs), .Rt(Rt), .stall(stall), .busy(busy),
        .RegWrite(RegWrite), .Rd(Rd), .WriteD(WriteD), .wb_err(wb_err)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        rsv_valid = 1'b0; rsv_rd = '0;
        Rs = '0; Rt = '0;
    endtask

    task automatic reset_dut();
        tick();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic reserve(input logic [ADDR_W-1:0] r);
        tick();
        rsv_valid = 1'b1;
        rsv_rd = r;
        #3;
        check("rsv_ready", {31'b0, rsv_ready}, 32'd1);
    endtask

    function automatic logic [EW-1:0] wr(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        return {r, d};
    endfunction

    // scoreboard monitor
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && RegWrite) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h:%0h required=none", Rd, WriteD);
                end else begin
                    check("commit", {4'b0, Rd, WriteD}, {4'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        idle_inputs();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #3;
        check("reset_regwrite", {31'b0, RegWrite}, 32'd0);
        check("reset_busy", {16'b0, busy}, 32'd0);
        check("reset_wb_err", {31'b0, wb_err}, 32'd0);

        // reset mid-write: r3 commit in progress and a new r3 request pending
        reserve(4'd3);
        tick();
        rsv_valid = 1'b1; rsv_rd = 4'd6;
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 24'h000033;
        #3;
        check("t1_alu_ready", {31'b0, alu_ready}, 32'd1);
        tick();
        rsv_valid = 1'b0;
        alu_data = 24'h00ABCD;
        #1;
        check("t1_regwrite_pre", {31'b0, RegWrite}, 32'd1);
        reset = 1'b1;
        #1;
        check("t1_regwrite_rst", {31'b0, RegWrite}, 32'd0);
        check("t1_busy_rst", {16'b0, busy}, 32'd0);
        check("t1_rd_rst", {28'b0, Rd}, 32'd0);
        check("t1_writed_rst", {8'b0, WriteD}, 32'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        #3;
        check("t1_no_write", {31'b0, RegWrite}, 32'd0);

        // single ALU write to a reserved register
        reserve(4'd5);
        tick();
        rsv_valid = 1'b0;
        check("t2_busy_set", {16'b0, busy}, 32'h0020);
        alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 24'h123456;
        #3;
        check("t2_alu_ready", {31'b0, alu_ready}, 32'd1);
        check("t2_mem_ready", {31'b0, mem_ready}, 32'd0);
        exp_q.push_back(wr(4'd5, 24'h123456));
        tick();
        alu_valid = 1'b0;
        #3;
        check("t2_busy_commit", {16'b0, busy}, 32'h0020);
        tick();
        check("t2_busy_clear", {16'b0, busy}, 32'h0000);
        check("t2_wb_err", {31'b0, wb_err}, 32'd0);

        // round-robin from a fresh pointer: ALU, MEM, ALU
        reset_dut();
        reserve(4'd1);
        reserve(4'd2);
        reserve(4'd3);
        tick();
        rsv_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 24'h111111;
        mem_valid = 1'b1; mem_rd = 4'd2; mem_data = 24'h222222;
        #3;
        check("t3_c1_alu", {31'b0, alu_ready}, 32'd1);
        check("t3_c1_mem", {31'b0, mem_ready}, 32'd0);
        exp_q.push_back(wr(4'd1, 24'h111111));
        tick();
        alu_rd = 4'd3; alu_data = 24'h333333;
        #3;
        check("t3_c2_alu", {31'b0, alu_ready}, 32'd0);
        check("t3_c2_mem", {31'b0, mem_ready}, 32'd1);
        exp_q.push_back(wr(4'd2, 24'h222222));
        tick();
        mem_data = 24'h222223;
        #3;
        check("t3_c3_alu", {31'b0, alu_ready}, 32'd1);
        check("t3_c3_mem", {31'b0, mem_ready}, 32'd0);
        exp_q.push_back(wr(4'd3, 24'h333333));
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #3;
        check("t3_idle_ready", {30'b0, alu_ready, mem_ready}, 32'd0);
        tick();
        tick();
        check("t3_busy", {16'b0, busy}, 32'd0);
        check("t3_wb_err", {31'b0, wb_err}, 32'd0);

        // operand hazard on Rs then Rt
        reserve(4'd7);
        tick();
        rsv_valid = 1'b0;
        Rs = 4'd7;
        alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 24'h777777;
        #3;
        check("t4_stall_rs", {31'b0, stall}, 32'd1);
        exp_q.push_back(wr(4'd7, 24'h777777));
        tick();
        alu_valid = 1'b0;
        Rs = 4'd0; Rt = 4'd7;
        #3;
        check("t4_stall_rt", {31'b0, stall}, 32'd1);
        tick();
        check("t4_stall_clear", {31'b0, stall}, 32'd0);
        Rt = 4'd0;

        // re-reserve during commit (set wins), refused without commit
        reserve(4'd4);
        tick();
        rsv_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd4; alu_data = 24'h444444;
        exp_q.push_back(wr(4'd4, 24'h444444));
        tick();
        alu_valid = 1'b0;
        rsv_valid = 1'b1; rsv_rd = 4'd4;
        #3;
        check("t5_rsv_commit", {31'b0, rsv_ready}, 32'd1);
        tick();
        check("t5_busy_setwins", {16'b0, busy}, 32'h0010);
        #3;
        check("t5_rsv_refused", {31'b0, rsv_ready}, 32'd0);
        tick();
        rsv_valid = 1'b0;
        check("t5_busy_hold", {16'b0, busy}, 32'h0010);
        alu_valid = 1'b1; alu_rd = 4'd4; alu_data = 24'h040404;
        exp_q.push_back(wr(4'd4, 24'h040404));
        tick();
        alu_valid = 1'b0;
        tick();
        check("t5_busy_clear", {16'b0, busy}, 32'd0);
        check("t5_wb_err", {31'b0, wb_err}, 32'd0);

        // load to an unreserved register: write happens, sticky error
        tick();
        mem_valid = 1'b1; mem_rd = 4'd9; mem_data = 24'h0F0F0F;
        #3;
        check("t6_mem_ready", {31'b0, mem_ready}, 32'd1);
        check("t6_alu_ready", {31'b0, alu_ready}, 32'd0);
        exp_q.push_back(wr(4'd9, 24'h0F0F0F));
        tick();
        mem_valid = 1'b0;
        check("t6_wb_err_set", {31'b0, wb_err}, 32'd1);
        tick();
        tick();
        check("t6_wb_err_sticky", {31'b0, wb_err}, 32'd1);
        reset_dut();
        check("t6_wb_err_reset", {31'b0, wb_err}, 32'd0);

        tick();
        tick();
        check("drain", exp_q.size(), 32'd0);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: ALU results and memory-load results.
- Each source uses a valid/ready handshake. The block grants one source per cycle, round-robin, and drives registered RegWrite/Rd/WriteD into the register file.
- Holds a per-register busy scoreboard: decode reserves a destination, and commit clears it. Decode gets a stall flag for operand hazards on Rs/Rt.

Parameters:
- DATA_W, 24, width of write data.
- ADDR_W, 4, register address width.
- NREGS, 16, number of registers; equals 2**ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load writeback request.
- mem_rd  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request accepted this cycle.
- rsv_valid  in  1  decode reserves a destination register.
- rsv_rd  in  ADDR_W  register being reserved.
- rsv_ready  out  1  reservation accepted.
- Rs  in  ADDR_W  decode source operand 1.
- Rt  in  ADDR_W  decode source operand 2.
- stall  out  1  a source operand is pending a write.
- busy  out  NREGS  scoreboard, one bit per register.
- RegWrite  out  1  register file write enable.
- Rd  out  ADDR_W  register file write address.
- WriteD  out  DATA_W  register file write data.
- wb_err  out  1  sticky error: write to an unreserved register.

Behaviour:
- Reset (asynchronous, immediate):
  - RegWrite=0, Rd=0, WriteD=0, busy=0, wb_err=0.
  - Round-robin pointer favours ALU.
  - In-flight requests are dropped; sources re-present after reset.
- Arbitration (combinational ready):
  - Only alu_valid: alu_ready=1.
  - Only mem_valid: mem_ready=1.
  - Both valid: grant the source NOT granted at the last transfer. After reset, ALU wins the first tie.
  - At most one ready is high per cycle. ready never asserts without the matching valid.
  - The pointer updates only on a transfer (valid&ready).
- Transfer and commit:
  - On a transfer edge, register RegWrite=1 and Rd/WriteD from the granted source.
  - With no transfer, RegWrite=0 next cycle. Rd/WriteD hold their last values.
  - Latency is 1 cycle from acceptance to the write strobe. Sustained throughput is 1 write/cycle.
  - Sources must hold rd/data stable while valid && !ready.
- Scoreboard:
  - Reserve: rsv_ready = !busy[rsv_rd] || (RegWrite && Rd==rsv_rd). On rsv_valid&&rsv_ready, busy[rsv_rd] is set at the edge.
  - Clear: at an edge with RegWrite=1, busy[Rd] clears. This is the same edge at which the register file captures the data.
  - Set and clear of the same register at the same edge: set wins, so the bit stays 1.
  - A reservation refused by rsv_ready leaves busy unchanged. Decode must retry.
- Error: a transfer whose rd has busy=0 at acceptance sets wb_err. The write still proceeds. Only reset clears wb_err.
- Stall: stall = busy[Rs] || busy[Rt], combinational, with no bypass. The register file read is valid the cycle after busy clears.

Test Plan:
- Reset mid-write: alu_valid with rd=3, data=0x00ABCD, then reset asserted before the edge → RegWrite=0, busy=0 immediately; no write occurs.
- Reserve r5, then alu_valid with rd=5, data=0x123456 → alu_ready=1; next cycle RegWrite=1, Rd=5, WriteD=0x123456; busy[5]=0 after that edge; wb_err=0.
- Reserve r1 and r2, then alu and mem both valid for 3 cycles with different data each cycle → grant order ALU, MEM, ALU; exactly one ready per cycle; the non-granted source holds.
- Reserve r7, then Rs=7 → stall=1 until the edge committing r7; stall=0 on the following cycle.
- r4 busy with commit RegWrite=1, Rd=4 in progress, and rsv_valid with rsv_rd=4 → rsv_ready=1; busy[4] stays 1 (set wins). With no commit in progress → rsv_ready=0.
- mem_valid with rd=9 and r9 not reserved → the write happens and wb_err=1, staying 1 until reset.
